// File: rtl/fp_div_if.sv
// Operand/result handshake bundle for the fp32 divider.
interface fp_div_if;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        input_stb;
    logic        busy;
    logic [31:0] output_z;
    logic        output_z_stb;

    modport master (output input_a, input_b, input_stb,
                    input  busy, output_z, output_z_stb);
    modport slave  (input  input_a, input_b, input_stb,
                    output busy, output_z, output_z_stb);
endinterface

// File: rtl/fp_div.sv
// IEEE-754 fp32 divider, multi-cycle FSM around a restoring long-division core.
// Define FP_DIV_FTZ_EN to flush denormal operands and underflowing results to signed zero.
module fp_div (
    input logic    clk,
    input logic    rst,
    fp_div_if.slave bus
);
    localparam int          DIV_ITERS = 50;
    localparam logic [5:0]  LAST_ITER = 6'(DIV_ITERS - 1);
    localparam logic [31:0] QNAN      = 32'hFFC00000;

    typedef enum logic [3:0] {
        GET_IN, SPECIAL_CASES, NORMALISE_A, NORMALISE_B, DIVIDE_0, DIVIDE_1,
        DIVIDE_2, NORMALISE_1, NORMALISE_2, ROUND, PACK, PUT_Z
    } state_t;

    state_t             state;
    logic [23:0]        a_m, b_m, z_m;
    logic signed [9:0]  a_e, b_e, z_e;
    logic               a_s, b_s, z_s;
    logic               guard, round_bit, sticky;
    logic [31:0]        z;
    logic [50:0]        quotient, dividend, divisor, remainder;
    logic [5:0]         count;

    logic [50:0] rem_sh;
    logic        rem_ge;
    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    always_comb begin
        rem_sh = (remainder << 1) | 51'(dividend[50]);
        rem_ge = (rem_sh >= divisor);
        a_nan  = (a_e == 10'sd128) && (a_m[22:0] != 23'd0);
        a_inf  = (a_e == 10'sd128) && (a_m[22:0] == 23'd0);
        b_nan  = (b_e == 10'sd128) && (b_m[22:0] != 23'd0);
        b_inf  = (b_e == 10'sd128) && (b_m[22:0] == 23'd0);
`ifdef FP_DIV_FTZ_EN
        // Denormals count as zero, so only the exponent matters.
        a_zero = (a_e == -10'sd127);
        b_zero = (b_e == -10'sd127);
`else
        a_zero = (a_e == -10'sd127) && (a_m[22:0] == 23'd0);
        b_zero = (b_e == -10'sd127) && (b_m[22:0] == 23'd0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= GET_IN;
            bus.output_z_stb <= 1'b0;
            bus.busy         <= 1'b0;
            bus.output_z     <= 32'd0;
        end else begin
            case (state)
                GET_IN: if (bus.input_stb) begin
                    a_m      <= {1'b0, bus.input_a[22:0]};
                    b_m      <= {1'b0, bus.input_b[22:0]};
                    a_e      <= 10'(bus.input_a[30:23]) - 10'sd127;
                    b_e      <= 10'(bus.input_b[30:23]) - 10'sd127;
                    a_s      <= bus.input_a[31];
                    b_s      <= bus.input_b[31];
                    bus.busy <= 1'b1;
                    state    <= SPECIAL_CASES;
                end
                SPECIAL_CASES: begin
                    state <= PUT_Z;
                    if (a_nan || b_nan || (a_inf && b_inf))
                        z <= QNAN;
                    else if (a_inf)
                        z <= {a_s ^ b_s, 8'hFF, 23'd0};
                    else if (b_inf)
                        z <= {a_s ^ b_s, 31'd0};
                    else if (b_zero)
                        z <= a_zero ? QNAN : {a_s ^ b_s, 8'hFF, 23'd0};
                    else if (a_zero)
                        z <= {a_s ^ b_s, 31'd0};
                    else begin
                        if (a_e == -10'sd127) a_e <= -10'sd126;
                        else                  a_m[23] <= 1'b1;
                        if (b_e == -10'sd127) b_e <= -10'sd126;
                        else                  b_m[23] <= 1'b1;
                        state <= NORMALISE_A;
                    end
                end
                NORMALISE_A: if (a_m[23]) state <= NORMALISE_B;
                    else begin
                        a_m <= a_m << 1;
                        a_e <= a_e - 10'sd1;
                    end
                NORMALISE_B: if (b_m[23]) state <= DIVIDE_0;
                    else begin
                        b_m <= b_m << 1;
                        b_e <= b_e - 10'sd1;
                    end
                DIVIDE_0: begin
                    z_s       <= a_s ^ b_s;
                    z_e       <= a_e - b_e;
                    quotient  <= 51'd0;
                    dividend  <= {a_m, 27'd0};
                    divisor   <= {27'd0, b_m};
                    remainder <= 51'd0;
                    count     <= 6'd0;
                    state     <= DIVIDE_1;
                end
                DIVIDE_1: begin
                    quotient  <= (quotient << 1) | 51'(rem_ge);
                    remainder <= rem_ge ? rem_sh - divisor : rem_sh;
                    dividend  <= dividend << 1;
                    count     <= count + 6'd1;
                    if (count == LAST_ITER) state <= DIVIDE_2;
                end
                DIVIDE_2: begin
                    // Quotient bit 26 carries the 2^0 weight of a_m/b_m.
                    z_m       <= quotient[26:3];
                    guard     <= quotient[2];
                    round_bit <= quotient[1];
                    sticky    <= quotient[0] | (remainder != 51'd0);
                    state     <= NORMALISE_1;
                end
                NORMALISE_1: if (!z_m[23]) begin
                        z_m       <= {z_m[22:0], guard};
                        guard     <= round_bit;
                        round_bit <= 1'b0;
                        z_e       <= z_e - 10'sd1;
                    end else state <= NORMALISE_2;
                NORMALISE_2: begin
`ifdef FP_DIV_FTZ_EN
                    if (z_e < -10'sd126) begin
                        z_m       <= 24'd0;
                        z_e       <= -10'sd126;
                        guard     <= 1'b0;
                        round_bit <= 1'b0;
                        sticky    <= 1'b0;
                    end
                    state <= ROUND;
`else
                    if (z_e < -10'sd126) begin
                        z_m       <= z_m >> 1;
                        z_e       <= z_e + 10'sd1;
                        guard     <= z_m[0];
                        round_bit <= guard;
                        sticky    <= sticky | round_bit;
                    end else state <= ROUND;
`endif
                end
                ROUND: begin
                    if (guard && (round_bit || sticky || z_m[0])) begin
                        z_m <= z_m + 24'd1;
                        if (z_m == 24'hFFFFFF) z_e <= z_e + 10'sd1;
                    end
                    state <= PACK;
                end
                PACK: begin
                    z[22:0]  <= z_m[22:0];
                    z[30:23] <= 8'(z_e + 10'sd127);
                    z[31]    <= z_s;
                    if (z_e == -10'sd126 && !z_m[23]) z[30:23] <= 8'd0;
                    if (z_e > 10'sd127) z <= {z_s, 8'hFF, 23'd0};
                    state <= PUT_Z;
                end
                PUT_Z: if (!bus.output_z_stb) begin
                        bus.output_z     <= z;
                        bus.output_z_stb <= 1'b1;
                    end else begin
                        bus.output_z_stb <= 1'b0;
                        bus.busy         <= 1'b0;
                        state            <= GET_IN;
                    end
                default: state <= GET_IN;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: values, strobe timing, specials, underflow, overflow, reset.
module tb_fp_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    fp_div_if bus();
    fp_div dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Starts one division and waits for the result strobe (bounded).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] z, output int lat, output bit seen);
        @(negedge clk);
        bus.input_a = a; bus.input_b = b; bus.input_stb = 1'b1;
        @(posedge clk); #1 bus.input_stb = 1'b0;
        lat = 0; seen = 1'b0; z = 32'hx;
        while (!seen && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (bus.output_z_stb === 1'b1) begin seen = 1'b1; z = bus.output_z; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.output_z_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb got %b want 0", bus.output_z_stb); end
        n_cmp++; if (bus.output_z !== 32'd0) begin n_bad++; $display("FAIL reset_z got %h want 00000000", bus.output_z); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] z; int lat; bit seen;
        run_op(32'h40C00000, 32'h40000000, z, lat, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL basic_timeout got no stb want stb"); end
        n_cmp++; if (z !== 32'h40400000) begin n_bad++; $display("FAIL basic_z got %h want 40400000", z); end
        n_cmp++; if (lat != 60) begin n_bad++; $display("FAIL basic_latency got %0d want 60", lat); end
        @(posedge clk); #1;
        n_cmp++; if (bus.output_z_stb !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width got %b want 0", bus.output_z_stb); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after got %b want 0", bus.busy); end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (bus.output_z !== 32'h40400000) begin n_bad++; $display("FAIL basic_hold got %h want 40400000", bus.output_z); end
    endtask

    task automatic test_round();
        logic [31:0] z; int lat; bit seen;
        run_op(32'h3F800000, 32'h40400000, z, lat, seen);
        n_cmp++; if (!seen || z !== 32'h3EAAAAAB) begin n_bad++; $display("FAIL round_z got %h want 3EAAAAAB", z); end
        n_cmp++; if (lat != 61) begin n_bad++; $display("FAIL round_latency got %0d want 61", lat); end
        @(posedge clk);
    endtask

    task automatic test_specials();
        logic [31:0] va [4] = '{32'h3F800000, 32'h00000000, 32'hBF800000, 32'h7FC00000};
        logic [31:0] vb [4] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h40000000};
        logic [31:0] vz [4] = '{32'h7F800000, 32'hFFC00000, 32'h80000000, 32'hFFC00000};
        logic [31:0] z; int lat; bit seen;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], z, lat, seen);
            n_cmp++; if (!seen || z !== vz[i]) begin n_bad++; $display("FAIL special_%0d_z got %h want %h", i, z, vz[i]); end
            n_cmp++; if (lat > 3) begin n_bad++; $display("FAIL special_%0d_latency got %0d want <=3", i, lat); end
            @(posedge clk);
        end
    endtask

    task automatic test_denormal();
        logic [31:0] z; int lat; bit seen;
`ifdef FP_DIV_FTZ_EN
        logic [31:0] exp0 = 32'h00000000;
        logic [31:0] exp1 = 32'h00000000;
`else
        logic [31:0] exp0 = 32'h00400000;
        logic [31:0] exp1 = 32'h00400000;
`endif
        run_op(32'h00800000, 32'h40000000, z, lat, seen);
        n_cmp++; if (!seen || z !== exp0) begin n_bad++; $display("FAIL underflow_z got %h want %h", z, exp0); end
        @(posedge clk);
        run_op(32'h00400000, 32'h3F800000, z, lat, seen);
        n_cmp++; if (!seen || z !== exp1) begin n_bad++; $display("FAIL denorm_in_z got %h want %h", z, exp1); end
        @(posedge clk);
    endtask

    task automatic test_overflow();
        logic [31:0] z; int lat; bit seen;
        run_op(32'h7F7FFFFF, 32'h3F000000, z, lat, seen);
        n_cmp++; if (!seen || z !== 32'h7F800000) begin n_bad++; $display("FAIL overflow_z got %h want 7F800000", z); end
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] z; int lat; bit seen; int pulses;
        // A strobe while busy must be ignored.
        @(negedge clk);
        bus.input_a = 32'h40C00000; bus.input_b = 32'h40000000; bus.input_stb = 1'b1;
        @(posedge clk); #1 bus.input_stb = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_mid got %b want 1", bus.busy); end
        bus.input_a = 32'h3F800000; bus.input_b = 32'h40400000; bus.input_stb = 1'b1;
        @(posedge clk); #1 bus.input_stb = 1'b0;
        seen = 1'b0; lat = 11; z = 32'hx;
        while (!seen && lat < 400) begin
            @(posedge clk); #1; lat++;
            if (bus.output_z_stb === 1'b1) begin seen = 1'b1; z = bus.output_z; end
        end
        n_cmp++; if (!seen || z !== 32'h40400000) begin n_bad++; $display("FAIL b2b_ignored_z got %h want 40400000", z); end
        n_cmp++; if (lat != 60) begin n_bad++; $display("FAIL b2b_ignored_latency got %0d want 60", lat); end
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (bus.output_z_stb === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL b2b_extra_pulse got %0d want 0", pulses); end
        // Next start right after a completed result.
        run_op(32'h3F800000, 32'h40400000, z, lat, seen);
        @(posedge clk);
        run_op(32'h40C00000, 32'h40000000, z, lat, seen);
        n_cmp++; if (!seen || z !== 32'h40400000) begin n_bad++; $display("FAIL b2b_second_z got %h want 40400000", z); end
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] z; int lat; bit seen; int pulses;
        @(negedge clk);
        bus.input_a = 32'h40C00000; bus.input_b = 32'h40000000; bus.input_stb = 1'b1;
        @(posedge clk); #1 bus.input_stb = 1'b0;
        // Divide loop is entered at edge 4, so 20 iterations are done after edge 24.
        repeat (24) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.output_z !== 32'd0) begin n_bad++; $display("FAIL midrst_z got %h want 00000000", bus.output_z); end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.output_z_stb === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL midrst_stray_stb got %0d want 0", pulses); end
        run_op(32'h3F800000, 32'h40400000, z, lat, seen);
        n_cmp++; if (!seen || z !== 32'h3EAAAAAB) begin n_bad++; $display("FAIL midrst_restart_z got %h want 3EAAAAAB", z); end
        @(posedge clk);
    endtask

    initial begin
        bus.input_a = 32'd0; bus.input_b = 32'd0; bus.input_stb = 1'b0;
        test_reset();
        test_basic();
        test_round();
        test_specials();
        test_denormal();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
